// File: rtl/ysyx_22041412_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: reset PC, widths, FSM states,
// buffer entry layout and PC alignment helper.
package ysyx_22041412_ifu_pkg;

  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam int          INSTR_W      = 32;
  localparam int          PC_W         = 64;
  localparam int          ENTRY_W      = PC_W + INSTR_W;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifu_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return pc & ~64'h3;
  endfunction

endpackage

// File: rtl/ysyx_22041412_ifu_fifo.sv
// DEPTH-entry synchronous FIFO of {pc,instr} pairs; flush beats push and pop.
module ysyx_22041412_ifu_fifo
  import ysyx_22041412_ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  ifu_entry_t             push_data,
  input  logic                   pop,
  output ifu_entry_t             pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ifu_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign do_push  = push && !flush && !full;
  assign do_pop   = pop && !flush && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: credit-limited in-order fetch, response buffer towards decode,
// and redirect handling that flushes the buffer and drops fetches still in flight.
module ysyx_22041412_ifu
  import ysyx_22041412_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC = IFU_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [63:0] if_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  ifu_state_e    state;
  ifu_state_e    state_next;
  logic [63:0]   fetch_pc;
  logic [63:0]   rsp_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] inflight_next;
  logic [CW-1:0] drop;
  logic [CW-1:0] drop_next;
  logic [CW-1:0] buf_count;
  logic [CW:0]   credit_used;
  logic          buf_full;
  logic          buf_empty;
  logic          req_fire;
  logic          rsp_keep;
  logic          pop;
  ifu_entry_t    head;
  ifu_entry_t    push_entry;

  // Requests still in flight and buffered entries share DEPTH credits, so the buffer cannot overflow.
  assign credit_used    = {1'b0, inflight} + {1'b0, buf_count};
  assign imem_req_valid = (state != ST_BOOT) && (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop == '0) && !redirect_valid;
  assign inflight_next  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);

  assign if_valid   = !buf_empty && !redirect_valid;
  assign pop        = if_valid && if_ready;
  assign if_instr   = buf_empty ? '0 : head.instr;
  assign if_pc      = buf_empty ? '0 : head.pc;
  assign push_entry = '{pc: rsp_pc, instr: imem_rsp_data};

  ysyx_22041412_ifu_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  always_comb begin
    state_next = state;
    drop_next  = drop;
    if (redirect_valid) begin
      drop_next = inflight_next;
    end else if (imem_rsp_valid && (drop != '0)) begin
      drop_next = drop - CW'(1);
    end
    unique case (state)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN, ST_DRAIN: begin
        if (redirect_valid) begin
          state_next = (inflight_next != '0) ? ST_DRAIN : ST_RUN;
        end else if ((state == ST_DRAIN) && (drop_next == '0)) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      state    <= state_next;
      inflight <= inflight_next;
      drop     <= drop_next;
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
        rsp_pc   <= align_pc(redirect_pc);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + 64'd4;
        if (rsp_keep) rsp_pc   <= rsp_pc + 64'd4;
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(imem_rsp_valid && (inflight == '0)));
  assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && buf_full && !pop));

endmodule
